// File: rtl/regfile_pkg.sv
// Shared constants and port-slice helper for the ID-stage register file.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 32;
  localparam int PEND_W_DEF = 2;
  localparam int ZERO_REG   = 0;

  // LSB offset of port 'port' inside a flat bus of 'width'-bit slices.
  function automatic int port_lsb(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending-writer counters, issue handshake, busy base terms, sticky underflow flag.
// Latency: counters update on posedge; issue_ready and busy terms are combinational.
// Backpressure: issue_ready drops when the destination counter is saturated and not retiring.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int NUM_RD = 2,
  parameter int PEND_W = PEND_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        busy_base,
  output logic [NUM_RD-1:0]        cnt_one,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic                     issue_valid,
  input  logic [ADDR_W-1:0]        issue_addr,
  output logic                     issue_ready,
  input  logic                     flush,
  output logic                     sb_err
);

  localparam logic [ADDR_W-1:0] ZERO_A  = ADDR_W'(ZERO_REG);
  localparam logic [PEND_W-1:0] CNT_MAX = '1;

  logic [PEND_W-1:0] cnt [DEPTH];
  logic              inc_any;
  logic              dec_any;
  logic              dec_same;
  logic [DEPTH-1:0]  inc_vec;
  logic [DEPTH-1:0]  dec_vec;

  assign dec_any     = wr_en && (wr_addr != ZERO_A);
  assign dec_same    = dec_any && (wr_addr == issue_addr);
  // A retiring writer frees its slot in the same cycle, so a saturated counter may still accept.
  assign issue_ready = !((issue_addr != ZERO_A) && (cnt[issue_addr] == CNT_MAX) && !dec_same);
  assign inc_any     = issue_valid && issue_ready && (issue_addr != ZERO_A);

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int r = 1; r < DEPTH; r++) begin
      inc_vec[r] = inc_any && (issue_addr == ADDR_W'(r));
      dec_vec[r] = dec_any && (wr_addr == ADDR_W'(r));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DEPTH; r++) cnt[r] <= '0;
      sb_err <= 1'b0;
    end else begin
      if (dec_any && (cnt[wr_addr] == '0)) sb_err <= 1'b1;
      // cnt[0] is never touched after reset and stays zero.
      for (int r = 1; r < DEPTH; r++) begin
        if (flush) begin
          cnt[r] <= '0;
        end else if (inc_vec[r] && !dec_vec[r]) begin
          cnt[r] <= cnt[r] + PEND_W'(1);
        end else if (dec_vec[r] && !inc_vec[r] && (cnt[r] != '0)) begin
          cnt[r] <= cnt[r] - PEND_W'(1);
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_busy
    logic [ADDR_W-1:0] ra;
    assign ra           = rd_addr[port_lsb(i, ADDR_W) +: ADDR_W];
    assign busy_base[i] = (cnt[ra] != '0);
    assign cnt_one[i]   = (cnt[ra] == PEND_W'(1));
  end

endmodule

// File: rtl/regfile_sb.sv
// Register file (r0 hardwired zero) with pending-write scoreboard; REGFILE_BYPASS_EN adds write-through.
// Latency: reads combinational, writes on posedge.
// Backpressure: issue_ready from the scoreboard; reads and writes never stall.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int NUM_RD = 2,
  parameter int PEND_W = PEND_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     issue_valid,
  input  logic [ADDR_W-1:0]        issue_addr,
  output logic                     issue_ready,
  input  logic                     flush,
  output logic                     sb_err
);

  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [NUM_RD-1:0] busy_base;
  logic [NUM_RD-1:0] cnt_one;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DEPTH; r++) regs[r] <= '0;
    end else if (wr_en && (wr_addr != ZERO_A)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  rf_scoreboard #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD),
    .PEND_W (PEND_W)
  ) u_sb (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_addr     (rd_addr),
    .busy_base   (busy_base),
    .cnt_one     (cnt_one),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .issue_valid (issue_valid),
    .issue_addr  (issue_addr),
    .issue_ready (issue_ready),
    .flush       (flush),
    .sb_err      (sb_err)
  );

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] arr_val;
    assign ra      = rd_addr[port_lsb(i, ADDR_W) +: ADDR_W];
    assign arr_val = (ra == ZERO_A) ? '0 : regs[ra];
`ifdef REGFILE_BYPASS_EN
    logic wr_hit;
    assign wr_hit = wr_en && (wr_addr == ra) && (ra != ZERO_A);
    assign rd_data[port_lsb(i, DATA_W) +: DATA_W] = wr_hit ? wr_data : arr_val;
    // The last outstanding writer retiring now makes the operand available this cycle.
    assign rd_busy[i] = busy_base[i] && !(cnt_one[i] && wr_hit);
`else
    logic unused_cnt_one;
    assign unused_cnt_one = cnt_one[i];
    assign rd_data[port_lsb(i, DATA_W) +: DATA_W] = arr_val;
    assign rd_busy[i] = busy_base[i];
`endif
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb (default parameters, PEND_W=2).
module tb_regfile_sb;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_busy;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [DW-1:0]    wr_data;
  logic             issue_valid;
  logic [AW-1:0]    issue_addr;
  logic             issue_ready;
  logic             flush;
  logic             sb_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_sb #(.DATA_W(DW), .DEPTH(32), .NUM_RD(NR), .PEND_W(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_busy     (rd_busy),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .issue_valid (issue_valid),
    .issue_addr  (issue_addr),
    .issue_ready (issue_ready),
    .flush       (flush),
    .sb_err      (sb_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Commit the current inputs on posedge, return at the following negedge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    wr_en = 1'b0; issue_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic do_issue(input logic [AW-1:0] a);
    issue_valid = 1'b1; issue_addr = a;
    step();
    issue_valid = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  function automatic logic [DW-1:0] port(input int i);
    return rd_data[i*DW +: DW];
  endfunction

  initial begin
    rst_n = 1'b0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    issue_valid = 1'b0; issue_addr = '0; flush = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    rd_addr = {5'd0, 5'd5};
    #1;
    chk("rst_rd0", port(0), 0);
    chk("rst_rd1", port(1), 0);
    chk("rst_busy", rd_busy, 2'b00);
    chk("rst_irdy", issue_ready, 1);
    chk("rst_err", sb_err, 0);

    // Normal write/read of r5 (reserved first so no underflow)
    do_issue(5'd5);
    #1 chk("r5_busy", rd_busy, 2'b01);
    do_write(5'd5, 32'hDEADBEEF);
    #1;
    chk("r5_data", port(0), 32'hDEADBEEF);
    chk("r5_busy_clr", rd_busy, 2'b00);
    do_write(5'd0, 32'h1234);
    #1;
    chk("r0_data", port(1), 0);
    chk("r0_no_err", sb_err, 0);

    // Saturation on r7
    rd_addr = {5'd0, 5'd7};
    do_issue(5'd7); do_issue(5'd7); do_issue(5'd7);
    #1 chk("r7_busy", rd_busy[0], 1);
    issue_valid = 1'b1; issue_addr = 5'd7;
    #1 chk("r7_sat_blk", issue_ready, 0);
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h77;
    #1 chk("r7_sat_retire", issue_ready, 1);
    step();
    idle();
    issue_addr = 5'd7;
    #1 chk("r7_still_sat", issue_ready, 0);
    do_write(5'd7, 32'h71); do_write(5'd7, 32'h72);
    #1 chk("r7_cnt1", rd_busy[0], 1);
    do_write(5'd7, 32'h73);
    #1;
    chk("r7_drained", rd_busy[0], 0);
    chk("r7_data", port(0), 32'h73);
    chk("r7_no_err", sb_err, 0);

    // Same-cycle write while reading r9 with cnt=1
    rd_addr = {5'd0, 5'd9};
    do_issue(5'd9);
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hA5A5;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("r9_byp_data", port(0), 32'hA5A5);
    chk("r9_byp_busy", rd_busy[0], 0);
`else
    chk("r9_old_data", port(0), 0);
    chk("r9_old_busy", rd_busy[0], 1);
`endif
    step();
    idle();
    #1;
    chk("r9_data_after", port(0), 32'hA5A5);
    chk("r9_busy_after", rd_busy[0], 0);

    // Underflow on r3 is sticky
    do_write(5'd3, 32'h33);
    #1 chk("r3_err", sb_err, 1);
    do_issue(5'd10);
    do_write(5'd10, 32'h10);
    #1 chk("err_sticky", sb_err, 1);

    // Flush with several busy registers; same-cycle issue is overridden, write lands
    rd_addr = {5'd12, 5'd11};
    do_issue(5'd11); do_issue(5'd12); do_issue(5'd12);
    #1 chk("pre_flush_busy", rd_busy, 2'b11);
    flush = 1'b1; issue_valid = 1'b1; issue_addr = 5'd13;
    wr_en = 1'b1; wr_addr = 5'd14; wr_data = 32'h1414;
    step();
    idle();
    #1 chk("post_flush_busy", rd_busy, 2'b00);
    rd_addr = {5'd14, 5'd13};
    #1;
    chk("flush_r13_busy", rd_busy, 2'b00);
    chk("flush_wr_r14", port(1), 32'h1414);

    // Asynchronous reset in the middle of traffic
    rd_addr = {5'd20, 5'd5};
    do_issue(5'd20);
    #1 chk("r20_busy", rd_busy, 2'b10);
    issue_valid = 1'b1; issue_addr = 5'd20;
    wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'h66;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rd0", port(0), 0);
    chk("arst_busy", rd_busy, 2'b00);
    chk("arst_err", sb_err, 0);
    chk("arst_irdy", issue_ready, 1);
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    #1 chk("arst_hold_rd0", port(0), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the ID-stage register file for the pipelined CPU.
- Provides configurable data width, depth and read-port count, with register 0 hardwired to zero.
- Adds an integrated per-register pending-write scoreboard. ID uses it to detect RAW hazards on in-flight destinations.
- Sits in ID: read ports serve the decoder; the write port is driven by WB; the issue port is driven when an instruction with a destination leaves ID.

Parameters:
- DATA_W, 32, register width in bits.
- DEPTH, 32, number of architectural registers (power of two, >=2).
- ADDR_W, $clog2(DEPTH), register index width.
- NUM_RD, 2, number of read ports (1..4).
- PEND_W, 2, width of each per-register pending-writer counter (maximum count 2^PEND_W-1).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- rd_addr  in  NUM_RD*ADDR_W  read indices; port i occupies bits [i*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  read data, same packing.
- rd_busy  out  NUM_RD  port i's register has an outstanding writer.
- wr_en  in  1  WB write strobe.
- wr_addr  in  ADDR_W  WB destination.
- wr_data  in  DATA_W  WB data.
- issue_valid  in  1  ID requests destination reservation.
- issue_addr  in  ADDR_W  destination being reserved.
- issue_ready  out  1  reservation can be accepted this cycle.
- flush  in  1  clear all pending counters (pipeline flush).
- sb_err  out  1  sticky: a writeback arrived for a register with zero pending count.

Behaviour:
- Reset, asynchronous on rst_n low and effective immediately, including mid-operation:
  - All registers are 0, all counters are 0, sb_err is 0.
  - rd_data follows the cleared array and reads 0.
  - rd_busy is all 0; issue_ready is 1.
- Reads are combinational and zero-latency: rd_data[i] = Reg[rd_addr[i]]. Index 0 always reads 0.
- Writes: on posedge, if wr_en and wr_addr != 0, Reg[wr_addr] <= wr_data. Writes to 0 are discarded.
- Scoreboard, one counter cnt[r] per register r != 0. cnt[0] is constant 0.
  - inc = issue_valid & issue_ready & issue_addr==r & r!=0.
  - dec = wr_en & wr_addr==r & r!=0.
  - inc & !dec: cnt+1. dec & !inc: cnt-1. Both: unchanged.
- Handshake: issue_ready = !(issue_addr!=0 & cnt[issue_addr]==max & !dec on same reg).
  - A saturated counter blocks issue unless that register retires in the same cycle.
  - Issue to register 0 is always ready and has no effect.
- Underflow: dec with cnt==0 leaves cnt at 0 and sets sb_err; sb_err clears only on reset.
- flush: on posedge all cnt <= 0, overriding same-cycle inc/dec. The register write still occurs.
- rd_busy[i] = (cnt[rd_addr[i]] != 0), modified by the optional feature.
- A register with DEPTH index outside range cannot occur because DEPTH is a power of two.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined:
  - rd_data[i] = wr_data when wr_en & wr_addr==rd_addr[i] & rd_addr[i]!=0 (write-through in the same cycle).
  - rd_busy[i] is deasserted when cnt==1 and that same write retires this cycle.
- Undefined:
  - rd_data shows the old value until the next cycle.
  - rd_busy reflects cnt only.
  - ID must stall one extra cycle.

Decomposition:
- Package regfile_pkg holds:
  - DATA_W_DEF=32, DEPTH_DEF=32, PEND_W_DEF=2.
  - ZERO_REG=0.
  - A function packing/unpacking a port index slice.
- One sub-module, rf_scoreboard: the counter array, issue_ready, rd_busy base terms, sb_err and flush.
- regfile_sb holds the storage array, read muxes and bypass logic.

Test Plan:
- Reset then read ports 0..1 at indices 5,0 -> rd_data 0,0; rd_busy 00; issue_ready 1.
- Write 0xDEADBEEF to r5, next cycle read r5 -> 0xDEADBEEF. Write 0x1234 to r0 -> reading r0 returns 0.
- Issue r7 three times (PEND_W=2) -> cnt 3, rd_busy 1. Fourth issue to r7 -> issue_ready 0. Same cycle with wr_en r7 -> issue_ready 1 and cnt stays 3.
- With REGFILE_BYPASS_EN: cnt[r9]=1, write 0xA5A5 to r9 while reading r9 -> rd_data 0xA5A5, rd_busy 0. Without the macro -> old value, rd_busy 1.
- Writeback r3 with cnt 0 -> sb_err 1, persists through later traffic. Flush with several busy registers -> all rd_busy 0 next cycle.
- Assert rst_n low asynchronously mid-burst -> all outputs return to reset values before the next clk edge.
